// File: rtl/nv_ram_pkg.sv
// ----------------------------------------------------------------------------
// nv_ram_pkg
//  Shared definitions for the parametrised rwsthp RAM family:
//   - nv_clog2      : elaboration-time ceil(log2(n)) helper
//   - WR_FWD_OLD/NEW: values of the write-to-read forwarding parameter
//   - nv_lane_merge : bitwise merge of old and new data under a bit mask
// ----------------------------------------------------------------------------
package nv_ram_pkg;

   // Widest data word the merge helper handles; callers cast to/from it.
   localparam int NV_MAX_W = 1024;

   // Same-cycle same-address read returns pre-write data or merged new data.
   localparam int WR_FWD_OLD = 0;
   localparam int WR_FWD_NEW = 1;

   function automatic int nv_clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

   // Bits with bit_m=1 come from new_d, all others from old_d.
   function automatic logic [NV_MAX_W-1:0] nv_lane_merge(
      input logic [NV_MAX_W-1:0] old_d,
      input logic [NV_MAX_W-1:0] new_d,
      input logic [NV_MAX_W-1:0] bit_m
   );
      return (old_d & ~bit_m) | (new_d & bit_m);
   endfunction

endpackage

// File: rtl/nv_ram_wflag_trk.sv
// ----------------------------------------------------------------------------
// nv_ram_wflag_trk
//  One "written" flag per RAM entry. Flags clear on async reset or on a
//  synchronous clear; a write in the same cycle as a clear still sets its
//  flag. Two combinational lookup ports (read and write address).
// Ports
//  clk, rst_n   clock, async active-low reset
//  set_i        set the flag at wr_idx_i (caller guarantees in-range index)
//  clr_i        clear all flags (set_i wins for its own entry)
//  wr_idx_i     write-side index, also looked up on wr_hit_o
//  rd_idx_i     read-side index, looked up on rd_hit_o
//  wr_hit_o     current flag at wr_idx_i (pre-update)
//  rd_hit_o     current flag at rd_idx_i (pre-update)
// ----------------------------------------------------------------------------
module nv_ram_wflag_trk #(
   parameter int DEPTH = 20,
   parameter int IDX_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             set_i,
   input  logic             clr_i,
   input  logic [IDX_W-1:0] wr_idx_i,
   input  logic [IDX_W-1:0] rd_idx_i,
   output logic             wr_hit_o,
   output logic             rd_hit_o
);

   logic [DEPTH-1:0] flags_q;
   logic [DEPTH-1:0] flags_d;

   // NOTE: every signal written in always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      flags_d = clr_i ? '0 : flags_q;
      if (set_i) flags_d[wr_idx_i] = 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) flags_q <= '0;
      else        flags_q <= flags_d;
   end

   assign wr_hit_o = flags_q[wr_idx_i];
   assign rd_hit_o = flags_q[rd_idx_i];

endmodule

// File: rtl/nv_ram_rwsthp_param.sv
// ----------------------------------------------------------------------------
// nv_ram_rwsthp_param
//  Parametrised 1R1W synchronous RAM: registered read (stage 1), output
//  register with bypass mux (stage 2), byte/lane-masked writes, per-entry
//  written tracking (unwritten entries read zero), optional write-to-read
//  forwarding and a sticky out-of-range address error.
// Ports
//  nvdla_core_clk/rstn  clock, async active-low reset
//  ra, re               read address / stage-1 capture enable
//  ore                  stage-2 (output register) capture enable
//  dout, dout_vld       registered read data and its valid flag
//  wa, we, wmask, di    write address / enable / lane mask / data
//  byp_sel, dbyp        stage 2 takes dbyp instead of stage-1 data
//  clr                  sync clear of written flags and addr_err
//  addr_err             sticky: an enabled access used address >= DEPTH
//  pwrbus_ram_pd        power-down bus, functionally ignored
// ----------------------------------------------------------------------------
module nv_ram_rwsthp_param
   import nv_ram_pkg::*;
#(
   parameter int DEPTH  = 20,
   parameter int WIDTH  = 32,
   parameter int MASK_W = 4,
   parameter int AW     = 5,
   parameter int WR_FWD = 0
) (
   input  logic              nvdla_core_clk,
   input  logic              nvdla_core_rstn,
   input  logic [AW-1:0]     ra,
   input  logic              re,
   input  logic              ore,
   output logic [WIDTH-1:0]  dout,
   output logic              dout_vld,
   input  logic [AW-1:0]     wa,
   input  logic              we,
   input  logic [MASK_W-1:0] wmask,
   input  logic [WIDTH-1:0]  di,
   input  logic              byp_sel,
   input  logic [WIDTH-1:0]  dbyp,
   input  logic              clr,
   output logic              addr_err,
   input  logic [31:0]       pwrbus_ram_pd
);

   localparam int IDX_W  = (nv_clog2(DEPTH) < 1) ? 1 : nv_clog2(DEPTH);
   localparam int LANE_W = WIDTH / MASK_W;
   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

   if (((WIDTH % MASK_W) != 0) || ((2**AW) < DEPTH)) begin : g_bad_cfg
      $fatal(1, "nv_ram_rwsthp_param: WIDTH must be a multiple of MASK_W and 2**AW >= DEPTH");
   end

   // Power-down bus has no functional effect.
   logic unused_pwrbus;
   assign unused_pwrbus = ^pwrbus_ram_pd;

   logic [WIDTH-1:0] mem [DEPTH];

   logic             wr_in_rng, rd_in_rng, wr_go, collide;
   logic [IDX_W-1:0] wa_idx, ra_idx;
   logic             wr_hit, rd_hit;
   logic [WIDTH-1:0] bit_mask, wr_old, wr_data, rd_old, rd_data;

   logic [WIDTH-1:0] s1_data_q, s1_data_d;
   logic             s1_vld_q, s1_vld_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             dout_vld_q, dout_vld_d;
   logic             addr_err_q, addr_err_d;

   assign wr_in_rng = ({1'b0, wa} < DEPTH_W);
   assign rd_in_rng = ({1'b0, ra} < DEPTH_W);
   assign wr_go     = we & wr_in_rng;
   assign collide   = wr_go & (wa == ra);
   assign wa_idx    = wa[IDX_W-1:0];
   assign ra_idx    = ra[IDX_W-1:0];

   for (genvar l = 0; l < MASK_W; l++) begin : g_lane
      assign bit_mask[l*LANE_W +: LANE_W] = {LANE_W{wmask[l]}};
   end

   nv_ram_wflag_trk #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_wflag (
      .clk      (nvdla_core_clk),
      .rst_n    (nvdla_core_rstn),
      .set_i    (wr_go),
      .clr_i    (clr),
      .wr_idx_i (wa_idx),
      .rd_idx_i (ra_idx),
      .wr_hit_o (wr_hit),
      .rd_hit_o (rd_hit)
   );

   // Unwritten entries behave as zero, so a partial first write zero-fills
   // the unmasked lanes and later reads stay deterministic.
   assign wr_old  = wr_hit ? mem[wa_idx] : '0;
   assign wr_data = WIDTH'(nv_lane_merge(NV_MAX_W'(wr_old), NV_MAX_W'(di), NV_MAX_W'(bit_mask)));
   assign rd_old  = rd_hit ? mem[ra_idx] : '0;

   always_comb begin
      rd_data = '0;
      if (rd_in_rng) begin
         if (collide && (WR_FWD == WR_FWD_NEW)) rd_data = wr_data;
         else                                   rd_data = rd_old;
      end
   end

   // NOTE: the storage array has no reset; only the written flags are
   // cleared, which is what makes unwritten entries read zero.
   always_ff @(posedge nvdla_core_clk) begin
      if (wr_go) mem[wa_idx] <= wr_data;
   end

   always_comb begin
      s1_data_d  = re  ? rd_data : s1_data_q;
      s1_vld_d   = re  | s1_vld_q;
      dout_d     = dout_q;
      dout_vld_d = dout_vld_q;
      if (ore) begin
         dout_d     = byp_sel ? dbyp : s1_data_q;
         dout_vld_d = byp_sel | s1_vld_q;
      end
      // Clear has priority over a same-cycle error.
      addr_err_d = clr ? 1'b0
                       : (addr_err_q | (we & ~wr_in_rng) | (re & ~rd_in_rng));
   end

   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         s1_data_q  <= '0;
         s1_vld_q   <= 1'b0;
         dout_q     <= '0;
         dout_vld_q <= 1'b0;
         addr_err_q <= 1'b0;
      end else begin
         s1_data_q  <= s1_data_d;
         s1_vld_q   <= s1_vld_d;
         dout_q     <= dout_d;
         dout_vld_q <= dout_vld_d;
         addr_err_q <= addr_err_d;
      end
   end

   assign dout     = dout_q;
   assign dout_vld = dout_vld_q;
   assign addr_err = addr_err_q;

endmodule

// File: tb/tb_nv_ram_rwsthp_param.sv
// ----------------------------------------------------------------------------
// tb_nv_ram_rwsthp_param
//  Drives two instances (WR_FWD=0 and WR_FWD=1) with identical stimulus.
//  Directed table vectors, hand-written reset/bypass sequences, then random
//  traffic compared against a behavioural model of the RAM.
// ----------------------------------------------------------------------------
module tb_nv_ram_rwsthp_param;

   localparam int DEPTH = 20;
   localparam int WIDTH = 32;
   localparam int MASK_W = 4;
   localparam int AW = 5;
   localparam int LANE_W = WIDTH / MASK_W;

   logic              clk;
   logic              rstn;
   logic [AW-1:0]     ra, wa;
   logic              re, ore, we, byp_sel, clr;
   logic [MASK_W-1:0] wmask;
   logic [WIDTH-1:0]  di, dbyp;
   logic [31:0]       pwrbus;
   logic [WIDTH-1:0]  dout0, dout1;
   logic              vld0, vld1, err0, err1;

   int total = 0;
   int bad   = 0;

   nv_ram_rwsthp_param #(.DEPTH(DEPTH), .WIDTH(WIDTH), .MASK_W(MASK_W), .AW(AW), .WR_FWD(0)) u_dut0 (
      .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
      .ra(ra), .re(re), .ore(ore), .dout(dout0), .dout_vld(vld0),
      .wa(wa), .we(we), .wmask(wmask), .di(di),
      .byp_sel(byp_sel), .dbyp(dbyp), .clr(clr), .addr_err(err0),
      .pwrbus_ram_pd(pwrbus)
   );

   nv_ram_rwsthp_param #(.DEPTH(DEPTH), .WIDTH(WIDTH), .MASK_W(MASK_W), .AW(AW), .WR_FWD(1)) u_dut1 (
      .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
      .ra(ra), .re(re), .ore(ore), .dout(dout1), .dout_vld(vld1),
      .wa(wa), .we(we), .wmask(wmask), .di(di),
      .byp_sel(byp_sel), .dbyp(dbyp), .clr(clr), .addr_err(err1),
      .pwrbus_ram_pd(pwrbus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   logic [WIDTH-1:0] m_mem [DEPTH];
   bit               m_wr  [DEPTH];
   logic [WIDTH-1:0] m_s1  [2];
   logic [WIDTH-1:0] m_dout[2];
   bit               m_s1v, m_vld, m_err;

   function automatic logic [WIDTH-1:0] merge_lanes(input logic [WIDTH-1:0] old_v,
                                                    input logic [WIDTH-1:0] new_v,
                                                    input logic [MASK_W-1:0] m);
      logic [WIDTH-1:0] r;
      r = old_v;
      for (int l = 0; l < MASK_W; l++)
         if (m[l]) r[l*LANE_W +: LANE_W] = new_v[l*LANE_W +: LANE_W];
      return r;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) m_wr[i] = 0;
      m_s1[0] = '0; m_s1[1] = '0; m_dout[0] = '0; m_dout[1] = '0;
      m_s1v = 0; m_vld = 0; m_err = 0;
   endtask

   // Applies one clock edge worth of the RAM rules to the model state.
   task automatic model_edge();
      int               wi, ri;
      bit               new_err;
      logic [WIDTH-1:0] base, wval, r_old;
      wi = int'(wa);
      ri = int'(ra);
      new_err = 0;
      if (ore) begin
         for (int k = 0; k < 2; k++) m_dout[k] = byp_sel ? dbyp : m_s1[k];
         m_vld = byp_sel | m_s1v;
      end
      base = (wi < DEPTH && m_wr[wi]) ? m_mem[wi] : '0;
      wval = merge_lanes(base, di, wmask);
      if (re) begin
         if (ri >= DEPTH) begin
            m_s1[0] = '0; m_s1[1] = '0; new_err = 1;
         end else begin
            r_old   = m_wr[ri] ? m_mem[ri] : '0;
            m_s1[0] = r_old;
            m_s1[1] = (we && wi == ri) ? wval : r_old;
         end
         m_s1v = 1;
      end
      if (clr) for (int i = 0; i < DEPTH; i++) m_wr[i] = 0;
      if (we) begin
         if (wi < DEPTH) begin m_mem[wi] = wval; m_wr[wi] = 1; end
         else new_err = 1;
      end
      m_err = clr ? 0 : (m_err | new_err);
   endtask

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle();
      we = 0; wa = '0; wmask = '0; di = '0; re = 0; ra = '0;
      ore = 0; byp_sel = 0; dbyp = '0; clr = 0;
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic check_both(input string name, input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1,
                             input logic v, input logic e);
      check({name, "_dout0"}, dout0, d0);
      check({name, "_dout1"}, dout1, d1);
      check({name, "_vld0"}, {31'd0, vld0}, {31'd0, v});
      check({name, "_vld1"}, {31'd0, vld1}, {31'd0, v});
      check({name, "_err0"}, {31'd0, err0}, {31'd0, e});
      check({name, "_err1"}, {31'd0, err1}, {31'd0, e});
   endtask

   typedef struct {
      logic              we;
      logic [AW-1:0]     wa;
      logic [MASK_W-1:0] wmask;
      logic [WIDTH-1:0]  di;
      logic              re;
      logic [AW-1:0]     ra;
      logic              ore;
      logic              byp;
      logic [WIDTH-1:0]  dbyp;
      logic              clr;
      logic [WIDTH-1:0]  exp_d0;
      logic [WIDTH-1:0]  exp_d1;
      logic              exp_vld;
      logic              exp_err;
   } vec_t;

   vec_t vecs[17];

   initial begin
      //           we wa  msk di            re ra  ore byp dbyp clr  exp_d0        exp_d1        vld err
      vecs[0]  = '{0, 0,  0, 32'h0,         1, 3,  0,  0, 32'h0, 0, 32'h0,        32'h0,        0, 0};
      vecs[1]  = '{0, 0,  0, 32'h0,         0, 0,  1,  0, 32'h0, 0, 32'h0,        32'h0,        1, 0};
      vecs[2]  = '{1, 3,  4'hF, 32'hA5A5A5A5, 0, 0, 0, 0, 32'h0, 0, 32'h0,        32'h0,        1, 0};
      vecs[3]  = '{1, 3,  4'h5, 32'h12345678, 0, 0, 0, 0, 32'h0, 0, 32'h0,        32'h0,        1, 0};
      vecs[4]  = '{0, 0,  0, 32'h0,         1, 3,  0,  0, 32'h0, 0, 32'h0,        32'h0,        1, 0};
      vecs[5]  = '{0, 0,  0, 32'h0,         0, 0,  1,  0, 32'h0, 0, 32'hA534A578, 32'hA534A578, 1, 0};
      vecs[6]  = '{1, 7,  4'hF, 32'h22222222, 0, 0, 0, 0, 32'h0, 0, 32'hA534A578, 32'hA534A578, 1, 0};
      vecs[7]  = '{1, 7,  4'hF, 32'h11111111, 1, 7, 0, 0, 32'h0, 0, 32'hA534A578, 32'hA534A578, 1, 0};
      vecs[8]  = '{0, 0,  0, 32'h0,         0, 0,  1,  0, 32'h0, 0, 32'h22222222, 32'h11111111, 1, 0};
      vecs[9]  = '{1, 25, 4'hF, 32'hFFFFFFFF, 0, 0, 0, 0, 32'h0, 0, 32'h22222222, 32'h11111111, 1, 1};
      vecs[10] = '{0, 0,  0, 32'h0,         1, 31, 0,  0, 32'h0, 0, 32'h22222222, 32'h11111111, 1, 1};
      vecs[11] = '{0, 0,  0, 32'h0,         0, 0,  1,  0, 32'h0, 0, 32'h0,        32'h0,        1, 1};
      vecs[12] = '{0, 0,  0, 32'h0,         1, 3,  1,  0, 32'h0, 0, 32'h0,        32'h0,        1, 1};
      vecs[13] = '{0, 0,  0, 32'h0,         0, 0,  1,  0, 32'h0, 1, 32'hA534A578, 32'hA534A578, 1, 0};
      vecs[14] = '{0, 0,  0, 32'h0,         1, 3,  0,  0, 32'h0, 0, 32'hA534A578, 32'hA534A578, 1, 0};
      vecs[15] = '{0, 0,  0, 32'h0,         1, 7,  1,  0, 32'h0, 0, 32'h0,        32'h0,        1, 0};
      vecs[16] = '{0, 0,  0, 32'h0,         0, 0,  1,  0, 32'h0, 0, 32'h0,        32'h0,        1, 0};

      idle();
      pwrbus = 32'h0;
      rstn = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;
      check_both("reset", 32'h0, 32'h0, 1'b0, 1'b0);

      // Directed table.
      for (int i = 0; i < 17; i++) begin
         we = vecs[i].we; wa = vecs[i].wa; wmask = vecs[i].wmask; di = vecs[i].di;
         re = vecs[i].re; ra = vecs[i].ra; ore = vecs[i].ore;
         byp_sel = vecs[i].byp; dbyp = vecs[i].dbyp; clr = vecs[i].clr;
         pwrbus = $urandom;
         step();
         check_both($sformatf("vec%0d", i), vecs[i].exp_d0, vecs[i].exp_d1, vecs[i].exp_vld, vecs[i].exp_err);
      end

      // Reset in the middle of the pipeline: read captured, output pending.
      idle(); we = 1; wa = 9; wmask = 4'hF; di = 32'hCAFEF00D; step();
      idle(); re = 1; ra = 9; step();
      idle(); ore = 1; step();
      check_both("pre_rst", 32'hCAFEF00D, 32'hCAFEF00D, 1'b1, 1'b0);
      idle(); re = 1; ra = 9; step();
      idle();
      #2 rstn = 1'b0;
      #1;
      check_both("mid_rst", 32'h0, 32'h0, 1'b0, 1'b0);
      model_reset();
      @(posedge clk); #1 rstn = 1'b1;

      // Bypass with no prior read, then hold with ore low.
      idle(); byp_sel = 1; dbyp = 32'hDEADBEEF; ore = 1; step();
      check_both("byp", 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 1'b0);
      idle(); byp_sel = 1; dbyp = 32'h0; step();
      check_both("byp_hold", 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 1'b0);
      // In-flight read was aborted: stage 1 holds reset values.
      idle(); ore = 1; step();
      check_both("aborted", 32'h0, 32'h0, 1'b0, 1'b0);
      // Written flags were reset, so entry 9 reads zero.
      idle(); re = 1; ra = 9; step();
      idle(); ore = 1; step();
      check_both("post_rst_rd", 32'h0, 32'h0, 1'b1, 1'b0);

      // Random traffic against the model.
      for (int n = 0; n < 600; n++) begin
         we      = ($urandom_range(0, 2) != 0);
         wa      = AW'($urandom_range(0, 23));
         wmask   = MASK_W'($urandom);
         di      = $urandom;
         re      = ($urandom_range(0, 2) != 0);
         ra      = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 23));
         if ($urandom_range(0, 15) == 0) ra = AW'($urandom_range(24, 31));
         if ($urandom_range(0, 15) == 0) wa = AW'($urandom_range(24, 31));
         ore     = ($urandom_range(0, 3) != 0);
         byp_sel = ($urandom_range(0, 5) == 0);
         dbyp    = $urandom;
         clr     = ($urandom_range(0, 29) == 0);
         pwrbus  = $urandom;
         step();
         check("rnd_dout0", dout0, m_dout[0]);
         check("rnd_dout1", dout1, m_dout[1]);
         check("rnd_vld0", {31'd0, vld0}, {31'd0, m_vld});
         check("rnd_vld1", {31'd0, vld1}, {31'd0, m_vld});
         check("rnd_err0", {31'd0, err0}, {31'd0, m_err});
         check("rnd_err1", {31'd0, err1}, {31'd0, m_err});
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
